// File: rtl/pll_rst_seq_pkg.sv
// pll_ctrl_pkg: shared types and defaults for the PLL reset sequencer.
//   pll_seq_state_t - sequencer state encoding
//   *_DEF           - default cycle counts for a 125 MHz reference clock
//   RETRY_W/LOSS_W  - widths of the retry and lock-loss counters
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN,
        ST_FAIL
    } pll_seq_state_t;

    localparam int RST_HOLD_CYC_DEF     = 125;     // 1 us
    localparam int LOCK_TIMEOUT_CYC_DEF = 125000;  // 1 ms
    localparam int LOCK_STABLE_CYC_DEF  = 1250;    // 10 us
    localparam int MAX_RETRY_DEF        = 7;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// pll_rst_seq_if: PLL/fabric-facing signals of the reset sequencer.
//   master - sequencer side: samples pll_locked/relock_req, drives resets and status
//   slave  - PLL wrapper / software side
interface pll_rst_seq_if;
    import pll_ctrl_pkg::*;

    logic               pll_locked;
    logic               relock_req;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fail;
    logic [RETRY_W-1:0] retry_cnt;
    logic [LOSS_W-1:0]  loss_cnt;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt
    );

    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt
    );
endinterface

// File: rtl/pll_rst_seq_sync2.sv
// sync2: two-flop synchroniser for a single asynchronous bit.
//   clk - destination clock
//   rst - synchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronised output (2 cycles of latency)
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset sequencer and lock supervisor (one per PLL).
//   refclk - free-running reference clock, the only clock
//   rst    - synchronous active-high reset
//   bus    - master side of pll_rst_seq_if (lock in, resets/status out)
// Holds the fabric reset until the PLL lock has been stable, and re-runs
// the PLL reset on lock timeout, lock loss in RUN or a relock request.
module pll_rst_seq
    import pll_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYC     = RST_HOLD_CYC_DEF,
    parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
    parameter int LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
    parameter int MAX_RETRY        = MAX_RETRY_DEF
) (
    input  logic          refclk,
    input  logic          rst,
    pll_rst_seq_if.master bus
);
    localparam int CNT_W = $clog2(max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC)) + 1;

    logic               lk;
    pll_seq_state_t     state, nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [LOSS_W-1:0]  loss_nxt;

    sync2 u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (lk)
    );

    // Next-state logic. relock_req overrides any lock/timeout event of the
    // same cycle, which is why a coincident lock loss is not counted.
    always_comb begin
        nxt       = state;
        cnt_nxt   = cnt;
        retry_nxt = bus.retry_cnt;
        loss_nxt  = bus.loss_cnt;
        if (bus.relock_req) begin
            nxt       = ST_RESET_PLL;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                ST_RESET_PLL: begin
                    if (cnt == CNT_W'(RST_HOLD_CYC - 1)) begin
                        nxt     = ST_WAIT_LOCK;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk) begin
                        nxt     = ST_STABILIZE;
                        cnt_nxt = '0;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                        retry_nxt = bus.retry_cnt + 1'b1;
                        cnt_nxt   = '0;
                        nxt       = (retry_nxt == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_RESET_PLL;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_STABILIZE: begin
                    if (!lk) begin
                        // back to waiting, with a fresh timeout window
                        nxt     = ST_WAIT_LOCK;
                        cnt_nxt = '0;
                    end else if (cnt == CNT_W'(LOCK_STABLE_CYC - 1)) begin
                        nxt       = ST_RUN;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lk) begin
                        nxt     = ST_RESET_PLL;
                        cnt_nxt = '0;
                        if (bus.loss_cnt != '1) loss_nxt = bus.loss_cnt + 1'b1;
                    end
                end
                ST_FAIL: begin
                    cnt_nxt = '0;
                end
                default: begin
                    nxt     = ST_RESET_PLL;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they switch on the same edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= ST_RESET_PLL;
            cnt           <= '0;
            bus.retry_cnt <= '0;
            bus.loss_cnt  <= '0;
            bus.pll_rst   <= 1'b1;
            bus.sys_rst   <= 1'b1;
            bus.ready     <= 1'b0;
            bus.fail      <= 1'b0;
        end else begin
            state         <= nxt;
            cnt           <= cnt_nxt;
            bus.retry_cnt <= retry_nxt;
            bus.loss_cnt  <= loss_nxt;
            bus.pll_rst   <= (nxt == ST_RESET_PLL) || (nxt == ST_FAIL);
            bus.sys_rst   <= (nxt != ST_RUN);
            bus.ready     <= (nxt == ST_RUN);
            bus.fail      <= (nxt == ST_FAIL);
        end
    end
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: scoreboard bench for pll_rst_seq with small cycle parameters.
// Expected output values are queued with the cycle they are due in and
// compared by a negedge monitor.
module tb_pll_rst_seq;
    localparam int HOLD = 4;
    localparam int TOUT = 20;
    localparam int STAB = 8;
    localparam int MAXR = 2;

    localparam int F_PLL   = 0;
    localparam int F_SYS   = 1;
    localparam int F_READY = 2;
    localparam int F_FAIL  = 3;
    localparam int F_RETRY = 4;
    localparam int F_LOSS  = 5;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    pll_rst_seq_if bus ();

    pll_rst_seq #(
        .RST_HOLD_CYC     (HOLD),
        .LOCK_TIMEOUT_CYC (TOUT),
        .LOCK_STABLE_CYC  (STAB),
        .MAX_RETRY        (MAXR)
    ) dut (
        .refclk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int fld(input int sel);
        case (sel)
            F_PLL:   return int'(bus.pll_rst);
            F_SYS:   return int'(bus.sys_rst);
            F_READY: return int'(bus.ready);
            F_FAIL:  return int'(bus.fail);
            F_RETRY: return int'(bus.retry_cnt);
            default: return int'(bus.loss_cnt);
        endcase
    endfunction

    // queue an expectation dt edges from now
    task automatic exp_at(input int dt, input int sel, input int val, input string tag);
        exp_t e;
        e.cyc = cyc + dt;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, fld(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // hold rst for 3 edges, queue reset-value checks, release rst
    task automatic do_reset();
        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        tick(3);
        exp_at(0, F_PLL, 1, "rst_pll_rst");
        exp_at(0, F_SYS, 1, "rst_sys_rst");
        exp_at(0, F_READY, 0, "rst_ready");
        exp_at(0, F_FAIL, 0, "rst_fail");
        exp_at(0, F_RETRY, 0, "rst_retry");
        exp_at(0, F_LOSS, 0, "rst_loss");
        rst = 1'b0;
    endtask

    initial begin
        // normal lock
        do_reset();
        exp_at(1, F_SYS, 1, "nl_sys_hold");
        exp_at(3, F_PLL, 1, "nl_pll_rst_last");
        exp_at(4, F_PLL, 0, "nl_pll_rst_end");
        tick(10);
        bus.pll_locked = 1'b1;
        exp_at(10, F_READY, 0, "nl_ready_early");
        exp_at(11, F_READY, 1, "nl_ready");
        exp_at(11, F_SYS, 0, "nl_sys_rel");
        exp_at(11, F_RETRY, 0, "nl_retry");
        tick(12);

        // 1-cycle lock loss in RUN, then re-lock
        bus.pll_locked = 1'b0;
        exp_at(2, F_READY, 1, "ll_ready_still");
        exp_at(2, F_LOSS, 0, "ll_loss_before");
        exp_at(3, F_READY, 0, "ll_ready_drop");
        exp_at(3, F_SYS, 1, "ll_sys_rst");
        exp_at(3, F_PLL, 1, "ll_pll_rst");
        exp_at(3, F_LOSS, 1, "ll_loss");
        exp_at(6, F_PLL, 1, "ll_pll_rst_last");
        exp_at(7, F_PLL, 0, "ll_pll_rst_end");
        exp_at(15, F_READY, 0, "ll_ready_early");
        exp_at(16, F_READY, 1, "ll_relock");
        tick(1);
        bus.pll_locked = 1'b1;
        tick(17);

        // unstable lock: high 5, low 1, high
        do_reset();
        tick(5);
        exp_at(8, F_PLL, 0, "ul_no_pll_rst_a");
        exp_at(11, F_READY, 0, "ul_no_early_run");
        exp_at(16, F_READY, 0, "ul_ready_early");
        exp_at(16, F_PLL, 0, "ul_no_pll_rst_b");
        exp_at(17, F_READY, 1, "ul_ready");
        exp_at(17, F_RETRY, 0, "ul_retry");
        bus.pll_locked = 1'b1;
        tick(5);
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(14);

        // lock never arrives: two timeouts -> FAIL
        do_reset();
        exp_at(23, F_PLL, 0, "to_wait1");
        exp_at(23, F_RETRY, 0, "to_retry0");
        exp_at(24, F_PLL, 1, "to_pulse2");
        exp_at(24, F_RETRY, 1, "to_retry1");
        exp_at(27, F_PLL, 1, "to_pulse2_last");
        exp_at(28, F_PLL, 0, "to_wait2");
        exp_at(47, F_FAIL, 0, "to_fail_early");
        exp_at(47, F_RETRY, 1, "to_retry1_hold");
        exp_at(48, F_FAIL, 1, "to_fail");
        exp_at(48, F_PLL, 1, "to_fail_pll");
        exp_at(48, F_RETRY, 2, "to_retry2");
        exp_at(60, F_FAIL, 1, "to_fail_hold");
        exp_at(60, F_PLL, 1, "to_pll_hold");
        exp_at(60, F_SYS, 1, "to_sys_hold");
        tick(62);

        // relock request out of FAIL
        bus.relock_req = 1'b1;
        exp_at(1, F_FAIL, 0, "rq_fail_clr");
        exp_at(1, F_RETRY, 0, "rq_retry_clr");
        exp_at(1, F_PLL, 1, "rq_pll_rst");
        exp_at(4, F_PLL, 1, "rq_pll_rst_last");
        exp_at(5, F_PLL, 0, "rq_pll_rst_end");
        tick(1);
        bus.relock_req = 1'b0;
        tick(4);
        bus.pll_locked = 1'b1;
        exp_at(11, F_READY, 1, "rq_run");
        tick(13);

        // relock request coincident with a lock loss
        bus.pll_locked = 1'b0;
        exp_at(3, F_LOSS, 0, "co_loss_same");
        exp_at(3, F_PLL, 1, "co_pll_rst");
        exp_at(3, F_READY, 0, "co_ready");
        exp_at(16, F_READY, 1, "co_run");
        exp_at(16, F_LOSS, 0, "co_loss_after");
        tick(2);
        bus.relock_req = 1'b1;
        tick(1);
        bus.relock_req = 1'b0;
        bus.pll_locked = 1'b1;
        tick(15);

        // loss counter saturation
        do_reset();
        tick(10);
        bus.pll_locked = 1'b1;
        exp_at(11, F_READY, 1, "sat_first_run");
        tick(12);
        for (int i = 0; i < 256; i++) begin
            bus.pll_locked = 1'b0;
            exp_at(3, F_LOSS, (i + 1 > 255) ? 255 : i + 1, "sat_loss");
            exp_at(16, F_READY, 1, "sat_run");
            tick(1);
            bus.pll_locked = 1'b1;
            tick(17);
        end

        // rst during STABILIZE
        bus.pll_locked = 1'b0;
        exp_at(8, F_PLL, 0, "rs_stab_pll");
        exp_at(10, F_READY, 0, "rs_stab_ready");
        tick(1);
        bus.pll_locked = 1'b1;
        tick(9);
        rst = 1'b1;
        exp_at(1, F_PLL, 1, "rs_pll_rst");
        exp_at(1, F_SYS, 1, "rs_sys_rst");
        exp_at(1, F_READY, 0, "rs_ready");
        exp_at(1, F_FAIL, 0, "rs_fail");
        exp_at(1, F_RETRY, 0, "rs_retry");
        exp_at(1, F_LOSS, 0, "rs_loss");
        tick(1);
        rst = 1'b0;
        exp_at(3, F_PLL, 1, "rs_pll_rst_last");
        exp_at(4, F_PLL, 0, "rs_pll_rst_end");
        exp_at(12, F_READY, 0, "rs_ready_early");
        exp_at(13, F_READY, 1, "rs_run");
        tick(15);

        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
